// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for axis_frame_gen: FSM state encoding,
// final-beat keep mask and incrementing-byte payload word builders.
package axis_frame_gen_pkg;

    localparam int MAX_DATA_W = 512;
    localparam int MAX_KEEP_W = MAX_DATA_W / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Low (len mod keep_w) bits set, or keep_w bits when the remainder is zero.
    function automatic logic [MAX_KEEP_W-1:0] final_keep_mask(input logic [31:0] len,
                                                              input int unsigned keep_w);
        logic [MAX_KEEP_W-1:0] mask;
        int unsigned rem;
        int unsigned lim;
        rem = len & (keep_w - 1);
        lim = (rem == 0) ? keep_w : rem;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            mask[i] = (i < lim);
        end
        return mask;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] payload_word(input logic [7:0] start);
        logic [MAX_DATA_W-1:0] word;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            word[8*i +: 8] = start + 8'(i);
        end
        return word;
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame transmitter: one command per frame, incrementing-byte payload.
// Optional bad-frame flag on tuser enabled by defining AXIS_FRAME_GEN_ERR_EN.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  s_cmd_len,
    input  logic [7:0]            s_cmd_seed,
    input  logic                  s_cmd_err,
    input  logic                  s_cmd_valid,
    output logic                  s_cmd_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    localparam int         KEEP_SHIFT = $clog2(KEEP_WIDTH);
    localparam logic [7:0] KEEP_STEP  = 8'(KEEP_WIDTH);

    state_t                state, state_next;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic [7:0]            next_byte;
    logic [KEEP_WIDTH-1:0] last_keep_r;

    logic                  cmd_accept, cmd_nonzero, beat_done, final_done, beat_load;
    logic [LEN_WIDTH-1:0]  cmd_beats;
    logic                  beat_last;
    logic [7:0]            beat_start;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic [DATA_WIDTH-1:0] beat_word, beat_data;

    assign cmd_accept  = s_cmd_valid && s_cmd_ready;
    assign cmd_nonzero = cmd_accept && (s_cmd_len != '0);
    assign beat_done   = m_axis_tvalid && m_axis_tready;
    assign final_done  = beat_done && m_axis_tlast;
    assign beat_load   = cmd_nonzero || (beat_done && !m_axis_tlast);
    assign cmd_beats   = LEN_WIDTH'(({1'b0, s_cmd_len} + (LEN_WIDTH+1)'(KEEP_WIDTH - 1)) >> KEEP_SHIFT);
    assign busy        = (state == ST_SEND);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_nonzero) state_next = ST_SEND;
            ST_SEND: if (final_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The first beat comes straight from the command; later beats from the running byte.
    always_comb begin
        beat_start = (state == ST_IDLE) ? s_cmd_seed : next_byte;
        beat_last  = (state == ST_IDLE) ? (cmd_beats == LEN_WIDTH'(1))
                                        : (beats_left == LEN_WIDTH'(1));
        beat_keep  = '1;
        if (beat_last) begin
            beat_keep = (state == ST_IDLE)
                      ? KEEP_WIDTH'(final_keep_mask(32'(s_cmd_len), KEEP_WIDTH))
                      : last_keep_r;
        end
        beat_word = DATA_WIDTH'(payload_word(beat_start));
        beat_data = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            beat_data[8*i +: 8] = beat_keep[i] ? beat_word[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_cmd_ready   <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= '0;
            beats_left    <= '0;
            next_byte     <= '0;
            last_keep_r   <= '0;
        end else begin
            s_cmd_ready <= (state_next == ST_IDLE);
            if (cmd_nonzero) begin
                last_keep_r <= KEEP_WIDTH'(final_keep_mask(32'(s_cmd_len), KEEP_WIDTH));
            end
            if (beat_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= beat_data;
                m_axis_tkeep  <= beat_keep;
                m_axis_tlast  <= beat_last;
                beats_left    <= ((state == ST_IDLE) ? cmd_beats : beats_left) - LEN_WIDTH'(1);
                next_byte     <= beat_start + KEEP_STEP;
            end else if (final_done) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tdata  <= '0;
                m_axis_tkeep  <= '0;
                m_axis_tlast  <= 1'b0;
                frame_count   <= frame_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef AXIS_FRAME_GEN_ERR_EN
    logic err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_r        <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else begin
            if (cmd_accept) err_r <= s_cmd_err;
            if (beat_load) begin
                m_axis_tuser <= beat_last && ((state == ST_IDLE) ? s_cmd_err : err_r);
            end else if (final_done) begin
                m_axis_tuser <= 1'b0;
            end
        end
    end
`else
    logic unused_err;
    assign unused_err   = s_cmd_err;
    assign m_axis_tuser = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed self-checking bench for axis_frame_gen (DATA_WIDTH=64).
module tb_axis_frame_gen;

    localparam int DATA_WIDTH = 64;
    localparam int KEEP_WIDTH = 8;
    localparam int LEN_WIDTH  = 16;
    localparam int CNT_WIDTH  = 32;

    logic                  clk;
    logic                  rst;
    logic [LEN_WIDTH-1:0]  s_cmd_len;
    logic [7:0]            s_cmd_seed;
    logic                  s_cmd_err;
    logic                  s_cmd_valid;
    logic                  s_cmd_ready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  frame_count;

    int checks = 0;
    int errors = 0;

    axis_frame_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_cmd_len    (s_cmd_len),
        .s_cmd_seed   (s_cmd_seed),
        .s_cmd_err    (s_cmd_err),
        .s_cmd_valid  (s_cmd_valid),
        .s_cmd_ready  (s_cmd_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .busy         (busy),
        .frame_count  (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed, input logic err);
        int n = 0;
        while (!s_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (s_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_wait: s_cmd_ready=%b required 1", s_cmd_ready);
        end
        s_cmd_len   = len;
        s_cmd_seed  = seed;
        s_cmd_err   = err;
        s_cmd_valid = 1'b1;
        tick();
        s_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if (s_cmd_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready: got %b need 0", s_cmd_ready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b need 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata: got %h need 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'h00) begin errors++; $display("FAIL rst_tkeep: got %h need 0", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b0)  begin errors++; $display("FAIL rst_tlast: got %b need 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== 1'b0)  begin errors++; $display("FAIL rst_tuser: got %b need 0", m_axis_tuser); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b need 0", busy); end
        checks++; if (frame_count !== 32'd0)  begin errors++; $display("FAIL rst_count: got %0d need 0", frame_count); end
        rst = 1'b0;
        tick();
        checks++; if (s_cmd_ready !== 1'b1)   begin errors++; $display("FAIL rst_release_ready: got %b need 1", s_cmd_ready); end
    endtask

    task automatic test_single_beat();
        m_axis_tready = 1'b1;
        send_cmd(16'd8, 8'h10, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %b need 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h1716151413121110) begin errors++; $display("FAIL single_tdata: got %h need 1716151413121110", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'hFF) begin errors++; $display("FAIL single_tkeep: got %h need ff", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1)  begin errors++; $display("FAIL single_tlast: got %b need 1", m_axis_tlast); end
        checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL single_busy: got %b need 1", busy); end
        checks++; if (s_cmd_ready !== 1'b0)   begin errors++; $display("FAIL single_ready_low: got %b need 0", s_cmd_ready); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_fall: got %b need 0", m_axis_tvalid); end
        checks++; if (frame_count !== 32'd1)  begin errors++; $display("FAIL single_count: got %0d need 1", frame_count); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL single_busy_fall: got %b need 0", busy); end
        checks++; if (s_cmd_ready !== 1'b1)   begin errors++; $display("FAIL single_ready_back: got %b need 1", s_cmd_ready); end
    endtask

    task automatic test_two_beat();
        m_axis_tready = 1'b1;
        send_cmd(16'd13, 8'hFE, 1'b0);
        checks++; if (m_axis_tdata !== 64'h050403020100FFFE) begin errors++; $display("FAIL two_b0_tdata: got %h need 050403020100fffe", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'hFF) begin errors++; $display("FAIL two_b0_tkeep: got %h need ff", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b0)  begin errors++; $display("FAIL two_b0_tlast: got %b need 0", m_axis_tlast); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL two_b1_tvalid: got %b need 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h0000000A09080706) begin errors++; $display("FAIL two_b1_tdata: got %h need 0000000a09080706", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'h1F) begin errors++; $display("FAIL two_b1_tkeep: got %h need 1f", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1)  begin errors++; $display("FAIL two_b1_tlast: got %b need 1", m_axis_tlast); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL two_tvalid_fall: got %b need 0", m_axis_tvalid); end
        checks++; if (frame_count !== 32'd2)  begin errors++; $display("FAIL two_count: got %0d need 2", frame_count); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic [63:0] pd = '0;
        logic [7:0]  pk = '0;
        logic        pl = 1'b0;
        logic [63:0] exp_d;
        m_axis_tready = 1'b0;
        send_cmd(16'd40, 8'h00, 1'b0);
        while (idx < 5 && cyc < 300) begin
            if (m_axis_tvalid) begin
                if (held) begin
                    checks++;
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {pd, pk, pl}) begin
                        errors++;
                        $display("FAIL bp_stable: got %h/%h/%b need %h/%h/%b", m_axis_tdata, m_axis_tkeep, m_axis_tlast, pd, pk, pl);
                    end
                end
                m_axis_tready = 1'($urandom_range(0, 1));
                if (m_axis_tready) begin
                    for (int b = 0; b < 8; b++) exp_d[8*b +: 8] = 8'(idx * 8 + b);
                    checks++; if (m_axis_tdata !== exp_d) begin errors++; $display("FAIL bp_tdata[%0d]: got %h need %h", idx, m_axis_tdata, exp_d); end
                    checks++; if (m_axis_tkeep !== 8'hFF) begin errors++; $display("FAIL bp_tkeep[%0d]: got %h need ff", idx, m_axis_tkeep); end
                    checks++; if (m_axis_tlast !== (idx == 4)) begin errors++; $display("FAIL bp_tlast[%0d]: got %b need %b", idx, m_axis_tlast, (idx == 4)); end
                    idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    pd = m_axis_tdata;
                    pk = m_axis_tkeep;
                    pl = m_axis_tlast;
                end
            end
            tick();
            cyc++;
        end
        m_axis_tready = 1'b1;
        checks++; if (idx != 5) begin errors++; $display("FAIL bp_beats: got %0d need 5", idx); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_fall: got %b need 0", m_axis_tvalid); end
        checks++; if (frame_count !== 32'd3)  begin errors++; $display("FAIL bp_count: got %0d need 3", frame_count); end
    endtask

    task automatic test_zero_len();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_axis_tready = 1'b1;
        send_cmd(16'd0, 8'h55, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_axis_tvalid !== 1'b0 || s_cmd_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL zero_idle[%0d]: tvalid=%b ready=%b busy=%b need 0/1/0", i, m_axis_tvalid, s_cmd_ready, busy);
            end
            tick();
        end
        checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL zero_count: got %0d need 0", frame_count); end
        send_cmd(16'd1, 8'hAA, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL len1_tvalid: got %b need 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'h00000000000000AA) begin errors++; $display("FAIL len1_tdata: got %h need aa", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'h01) begin errors++; $display("FAIL len1_tkeep: got %h need 01", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1)  begin errors++; $display("FAIL len1_tlast: got %b need 1", m_axis_tlast); end
        tick();
        checks++; if (frame_count !== 32'd1)  begin errors++; $display("FAIL len1_count: got %0d need 1", frame_count); end
    endtask

    task automatic test_mid_reset();
        m_axis_tready = 1'b1;
        send_cmd(16'd64, 8'h00, 1'b0);
        tick();
        tick();
        checks++; if (m_axis_tdata !== 64'h1716151413121110) begin errors++; $display("FAIL midrst_b2_tdata: got %h need 1716151413121110", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL midrst_b2_tlast: got %b need 0", m_axis_tlast); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b need 0", m_axis_tvalid); end
        checks++; if (frame_count !== 32'd0)  begin errors++; $display("FAIL midrst_count: got %0d need 0", frame_count); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL midrst_busy: got %b need 0", busy); end
        checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL midrst_tdata: got %h need 0", m_axis_tdata); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_no_resume: got %b need 0", m_axis_tvalid); end
        send_cmd(16'd8, 8'h30, 1'b0);
        checks++; if (m_axis_tdata !== 64'h3736353433323130) begin errors++; $display("FAIL fresh_tdata: got %h need 3736353433323130", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 8'hFF) begin errors++; $display("FAIL fresh_tkeep: got %h need ff", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b1)  begin errors++; $display("FAIL fresh_tlast: got %b need 1", m_axis_tlast); end
        tick();
        checks++; if (frame_count !== 32'd1)  begin errors++; $display("FAIL fresh_count: got %0d need 1", frame_count); end
    endtask

    task automatic test_tuser();
        logic exp_user;
`ifdef AXIS_FRAME_GEN_ERR_EN
        exp_user = 1'b1;
`else
        exp_user = 1'b0;
`endif
        m_axis_tready = 1'b1;
        send_cmd(16'd16, 8'h00, 1'b1);
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL tuser_b0: got %b need 0", m_axis_tuser); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL tuser_b0_tlast: got %b need 0", m_axis_tlast); end
        tick();
        checks++; if (m_axis_tuser !== exp_user) begin errors++; $display("FAIL tuser_b1: got %b need %b", m_axis_tuser, exp_user); end
        checks++; if (m_axis_tdata !== 64'h0F0E0D0C0B0A0908) begin errors++; $display("FAIL tuser_b1_tdata: got %h need 0f0e0d0c0b0a0908", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL tuser_b1_tlast: got %b need 1", m_axis_tlast); end
        tick();
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL tuser_after: got %b need 0", m_axis_tuser); end
        checks++; if (frame_count !== 32'd2) begin errors++; $display("FAIL tuser_count: got %0d need 2", frame_count); end
    endtask

    initial begin
        rst           = 1'b1;
        s_cmd_len     = '0;
        s_cmd_seed    = '0;
        s_cmd_err     = 1'b0;
        s_cmd_valid   = 1'b0;
        m_axis_tready = 1'b0;
        test_reset();
        test_single_beat();
        test_two_beat();
        test_backpressure();
        test_zero_len();
        test_mid_reset();
        test_tuser();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
